johnson_counter: RTL and testbench

- Free-running, parameterisable twisted-ring (Johnson) counter.
- Steps through 2*WIDTH states, one per clock, and presents the raw ring value.
- Also presents the decoded phase index, a one-hot phase vector, a wrap pulse and an illegal-state flag.
- Used as a glitch-free phase/sequence generator for downstream timing logic; illegal ring states are self-corrected.

---
 rtl/johnson_counter.sv | 69 ++++++
 tb/tb_johnson_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/johnson_counter.sv
// Free-running twisted-ring (Johnson) counter with phase decode, wrap pulse
// and illegal-state detection; illegal ring states reload zero on the next edge.
module johnson_counter #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [WIDTH-1:0]   Count_out,
    output logic [PW-1:0]      Phase,
    output logic [2*WIDTH-1:0] Decode,
    output logic               Wrap,
    output logic               Illegal
);

    logic [WIDTH-1:0] ring;
    logic [WIDTH-1:0] thermo_lo;
    logic [WIDTH-1:0] thermo_hi;
    int unsigned      ones;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ring <= '0;
        end else if (Illegal) begin
            ring <= '0;
        end else begin
            ring <= {~ring[0], ring[WIDTH-1:1]};
        end
    end

    assign Count_out = ring;

    // A legal ring is a thermometer code anchored at either end, so it must
    // equal one of the two patterns built from its own population count.
    always_comb begin
        ones = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + {31'd0, ring[i]};
        end
        thermo_lo = '0;
        thermo_hi = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            thermo_lo[i] = (i < ones);
            thermo_hi[i] = (i >= WIDTH - ones);
        end
        Illegal = (ring != thermo_lo) && (ring != thermo_hi);
    end

    always_comb begin
        Phase = '0;
        if (!Illegal && (ring != '0)) begin
            if (ring[WIDTH-1]) begin
                Phase = PW'(ones);
            end else begin
                Phase = PW'(2*WIDTH - ones);
            end
        end
    end

    always_comb begin
        Decode = '0;
        for (int unsigned i = 0; i < 2*WIDTH; i++) begin
            Decode[i] = !Illegal && (Phase == PW'(i));
        end
    end

    assign Wrap = !Illegal && (Phase == PW'(2*WIDTH - 1));

endmodule

// File: tb/tb_johnson_counter.sv
// Directed bench for johnson_counter: WIDTH=4 main instance plus a WIDTH=3 instance.
module tb_johnson_counter;

    logic       Clock;
    logic       Reset;
    logic [3:0] count4;
    logic [2:0] phase4;
    logic [7:0] decode4;
    logic       wrap4;
    logic       illegal4;
    logic [2:0] count3;
    logic [2:0] phase3;
    logic [5:0] decode3;
    logic       wrap3;
    logic       illegal3;

    int unsigned n_cmp;
    int unsigned n_bad;

    johnson_counter #(.WIDTH(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Count_out (count4),
        .Phase     (phase4),
        .Decode    (decode4),
        .Wrap      (wrap4),
        .Illegal   (illegal4)
    );

    johnson_counter #(.WIDTH(3)) dut3 (
        .Clock     (Clock),
        .Reset     (Reset),
        .Count_out (count3),
        .Phase     (phase3),
        .Decode    (decode3),
        .Wrap      (wrap3),
        .Illegal   (illegal3)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " count"},   {28'd0, count4}, 32'h0);
        check_val({tag, " phase"},   {29'd0, phase4}, 32'h0);
        check_val({tag, " decode"},  {24'd0, decode4}, 32'h01);
        check_val({tag, " wrap"},    {31'd0, wrap4}, 32'h0);
        check_val({tag, " illegal"}, {31'd0, illegal4}, 32'h0);
    endtask

    // Hand-computed sequences after each rising edge, starting from zero.
    logic [3:0] seq4   [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [2:0] ph4    [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [7:0] dec4   [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [2:0] seq3   [6] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    logic [2:0] ph3    [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

    initial begin
        logic [3:0] prev4;
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b0;

        repeat (3) begin
            @(negedge Clock);
            check_reset_state("reset");
            check_val("reset count3", {29'd0, count3}, 32'h0);
        end

        Reset = 1'b1;
        prev4 = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clock);
            check_val("seq count",   {28'd0, count4}, {28'd0, seq4[i % 8]});
            check_val("seq phase",   {29'd0, phase4}, {29'd0, ph4[i % 8]});
            check_val("seq decode",  {24'd0, decode4}, {24'd0, dec4[i % 8]});
            check_val("seq wrap",    {31'd0, wrap4}, {31'd0, (seq4[i % 8] == 4'b0001)});
            check_val("seq illegal", {31'd0, illegal4}, 32'h0);
            check_val("hamming",     $countones(prev4 ^ count4), 32'd1);
            prev4 = count4;
            check_val("w3 count",    {29'd0, count3}, {29'd0, seq3[i % 6]});
            check_val("w3 phase",    {29'd0, phase3}, {29'd0, ph3[i % 6]});
            check_val("w3 wrap",     {31'd0, wrap3}, {31'd0, (seq3[i % 6] == 3'b001)});
            check_val("w3 illegal",  {31'd0, illegal3}, 32'h0);
        end

        repeat (3) @(negedge Clock);
        check_val("pre-reset count", {28'd0, count4}, 32'hE);
        #5;
        Reset = 1'b0;
        #1;
        check_reset_state("async reset");
        @(negedge Clock);
        check_reset_state("held reset");
        Reset = 1'b1;
        @(negedge Clock);
        check_val("restart count", {28'd0, count4}, 32'h8);
        check_val("restart phase", {29'd0, phase4}, 32'h1);

        @(negedge Clock);
        force dut.ring = 4'b1010;
        #1;
        check_val("illegal flag",   {31'd0, illegal4}, 32'h1);
        check_val("illegal decode", {24'd0, decode4}, 32'h0);
        check_val("illegal phase",  {29'd0, phase4}, 32'h0);
        check_val("illegal wrap",   {31'd0, wrap4}, 32'h0);
        release dut.ring;
        #1;
        check_val("illegal held", {28'd0, count4}, 32'hA);
        @(negedge Clock);
        check_val("recover count",   {28'd0, count4}, 32'h0);
        check_val("recover illegal", {31'd0, illegal4}, 32'h0);
        check_val("recover decode",  {24'd0, decode4}, 32'h01);
        @(negedge Clock);
        check_val("resume count", {28'd0, count4}, 32'h8);
        @(negedge Clock);
        check_val("resume count2", {28'd0, count4}, 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
